// File: rtl/mccpu_ctrl_fsm.sv
// ----------------------------------------------------------------------------
// mccpu_ctrl_fsm
//   Multicycle MIPS control unit. Walks one instruction at a time through
//   FETCH -> DCODE -> EXE -> MEM -> WB and drives every datapath enable and
//   mux select from the current state plus the latched IR fields Op/Funct
//   and the ALU Zero flag.
//
// Ports
//   clk      in   clock, all state changes on the rising edge
//   rst      in   synchronous active-high reset
//   Op       in   IR[31:26], valid from DCODE onward
//   Funct    in   IR[5:0]
//   Zero     in   ALU zero flag (combinational)
//   PCWrite  out  PC load
//   IRWrite  out  IR load
//   MemWrite out  data memory write
//   RFWrite  out  register file write
//   IorD     out  memory address: 0=PC, 1=ALUOut
//   ALUSrcA  out  0=A reg, 1=shamt IR[10:6]
//   ALUSrcB  out  0=B reg, 1=extended imm16
//   EXTOp    out  1=sign-extend imm16, 0=zero-extend
//   ALUOp    out  ALU operation code, ALU_NOP outside EXE
//   NPCOp    out  00=PC+4, 01=branch, 10=jump, 11=jr
//   WDSel    out  RF write data: 00=ALUOut, 01=MDR, 10=PC
//   GPRSel   out  RF write index: 00=rd, 01=rt, 10=31
//   state    out  current state (debug)
//   illegal  out  1-cycle pulse after DCODE of an undecodable instruction
//   done     out  1-cycle pulse in the cycle after an instruction's last state
// ----------------------------------------------------------------------------
module mccpu_ctrl_fsm #(
    parameter int JR_EN = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] Op,
    input  logic [5:0] Funct,
    input  logic       Zero,
    output logic       PCWrite,
    output logic       IRWrite,
    output logic       MemWrite,
    output logic       RFWrite,
    output logic       IorD,
    output logic       ALUSrcA,
    output logic       ALUSrcB,
    output logic       EXTOp,
    output logic [3:0] ALUOp,
    output logic [1:0] NPCOp,
    output logic [1:0] WDSel,
    output logic [1:0] GPRSel,
    output logic [2:0] state,
    output logic       illegal,
    output logic       done
);

    localparam logic [2:0] S_FETCH = 3'd0;
    localparam logic [2:0] S_DCODE = 3'd1;
    localparam logic [2:0] S_EXE   = 3'd2;
    localparam logic [2:0] S_MEM   = 3'd3;
    localparam logic [2:0] S_WB    = 3'd4;

    // ALU operation codes (ctrl_encode_def.v ALU_* values)
    localparam logic [3:0] ALU_NOP  = 4'd0;
    localparam logic [3:0] ALU_ADD  = 4'd1;
    localparam logic [3:0] ALU_SUB  = 4'd2;
    localparam logic [3:0] ALU_AND  = 4'd3;
    localparam logic [3:0] ALU_OR   = 4'd4;
    localparam logic [3:0] ALU_NOR  = 4'd5;
    localparam logic [3:0] ALU_SLT  = 4'd6;
    localparam logic [3:0] ALU_SLTU = 4'd7;
    localparam logic [3:0] ALU_SLL  = 4'd8;
    localparam logic [3:0] ALU_SRL  = 4'd9;
    localparam logic [3:0] ALU_LUI  = 4'd10;

    // R-type function code to ALU operation; shifts share SLL/SRL with
    // their variable forms, the operand source is chosen by ALUSrcA.
    function automatic logic [3:0] rtype_aluop(input logic [5:0] fn);
        case (fn)
            6'h21:         rtype_aluop = ALU_ADD;
            6'h23:         rtype_aluop = ALU_SUB;
            6'h24:         rtype_aluop = ALU_AND;
            6'h25:         rtype_aluop = ALU_OR;
            6'h27:         rtype_aluop = ALU_NOR;
            6'h2A:         rtype_aluop = ALU_SLT;
            6'h2B:         rtype_aluop = ALU_SLTU;
            6'h00, 6'h04:  rtype_aluop = ALU_SLL;
            6'h02, 6'h06:  rtype_aluop = ALU_SRL;
            default:       rtype_aluop = ALU_NOP;
        endcase
    endfunction

    logic       is_rtype, is_itype, is_lw, is_sw, is_beq, is_j, is_jal, is_jr;
    logic       is_jump, decodable;
    logic [2:0] state_nxt;
    logic       last_nxt, bad_nxt;

    assign is_rtype  = (Op == 6'h00) && (Funct inside {6'h21, 6'h23, 6'h24, 6'h25, 6'h27,
                                                       6'h2A, 6'h2B, 6'h00, 6'h02, 6'h04, 6'h06});
    assign is_jr     = (JR_EN != 0) && (Op == 6'h00) && (Funct == 6'h08);
    assign is_itype  = Op inside {6'h08, 6'h09, 6'h0A, 6'h0D, 6'h0F};
    assign is_lw     = (Op == 6'h23);
    assign is_sw     = (Op == 6'h2B);
    assign is_beq    = (Op == 6'h04);
    assign is_j      = (Op == 6'h02);
    assign is_jal    = (Op == 6'h03);
    assign is_jump   = is_j | is_jal | is_jr;
    assign decodable = is_rtype | is_itype | is_lw | is_sw | is_beq | is_jump;

    always_comb begin
        PCWrite   = 1'b0;
        IRWrite   = 1'b0;
        MemWrite  = 1'b0;
        RFWrite   = 1'b0;
        IorD      = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 1'b0;
        EXTOp     = 1'b0;
        ALUOp     = ALU_NOP;
        NPCOp     = 2'b00;
        WDSel     = 2'b00;
        GPRSel    = 2'b00;
        state_nxt = S_FETCH;
        last_nxt  = 1'b0;
        bad_nxt   = 1'b0;

        case (state)
            S_FETCH: begin
                IRWrite   = 1'b1;
                PCWrite   = 1'b1;
                state_nxt = S_DCODE;
            end
            S_DCODE: begin
                if (is_jump) begin
                    PCWrite  = 1'b1;
                    NPCOp    = is_jr ? 2'b11 : 2'b10;
                    last_nxt = 1'b1;
                    if (is_jal) begin
                        RFWrite = 1'b1;
                        GPRSel  = 2'b10;
                        WDSel   = 2'b10;
                    end
                end else if (decodable) begin
                    state_nxt = S_EXE;
                end else begin
                    bad_nxt = 1'b1;
                end
            end
            S_EXE: begin
                state_nxt = S_WB;
                if (Op == 6'h00) begin
                    ALUOp   = rtype_aluop(Funct);
                    ALUSrcA = (Funct == 6'h00) || (Funct == 6'h02);
                end else if (is_beq) begin
                    ALUOp     = ALU_SUB;
                    PCWrite   = Zero;
                    NPCOp     = 2'b01;
                    last_nxt  = 1'b1;
                    state_nxt = S_FETCH;
                end else if (is_lw || is_sw) begin
                    ALUOp     = ALU_ADD;
                    ALUSrcB   = 1'b1;
                    EXTOp     = 1'b1;
                    state_nxt = S_MEM;
                end else begin
                    ALUSrcB = 1'b1;
                    case (Op)
                        6'h08, 6'h09: begin ALUOp = ALU_ADD; EXTOp = 1'b1; end
                        6'h0A:        begin ALUOp = ALU_SLT; EXTOp = 1'b1; end
                        6'h0D:        ALUOp = ALU_OR;
                        6'h0F:        ALUOp = ALU_LUI;
                        default:      ALUOp = ALU_NOP;
                    endcase
                end
            end
            S_MEM: begin
                IorD = 1'b1;
                if (is_sw) begin
                    MemWrite = 1'b1;
                    last_nxt = 1'b1;
                end else if (is_lw) begin
                    state_nxt = S_WB;
                end
            end
            S_WB: begin
                RFWrite  = 1'b1;
                last_nxt = 1'b1;
                if (is_lw) begin
                    GPRSel = 2'b01;
                    WDSel  = 2'b01;
                end else if (Op != 6'h00) begin
                    GPRSel = 2'b01;
                end
            end
            default: ;  // unreachable encodings fall back to FETCH, no enables
        endcase

        // Reset suppresses every write and select in the same cycle.
        if (rst) begin
            PCWrite  = 1'b0;
            IRWrite  = 1'b0;
            MemWrite = 1'b0;
            RFWrite  = 1'b0;
            IorD     = 1'b0;
            ALUSrcA  = 1'b0;
            ALUSrcB  = 1'b0;
            EXTOp    = 1'b0;
            ALUOp    = ALU_NOP;
            NPCOp    = 2'b00;
            WDSel    = 2'b00;
            GPRSel   = 2'b00;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_FETCH;
            illegal <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_nxt;
            illegal <= bad_nxt;
            done    <= last_nxt;
        end
    end

endmodule

// File: tb/tb_mccpu_ctrl_fsm.sv
module tb_mccpu_ctrl_fsm;

    localparam logic [3:0] ALU_NOP = 4'd0;
    localparam logic [3:0] ALU_ADD = 4'd1;
    localparam logic [3:0] ALU_SUB = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd4;
    localparam logic [3:0] ALU_SLL = 4'd8;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] Op;
    logic [5:0] Funct;
    logic       Zero;
    logic       PCWrite, IRWrite, MemWrite, RFWrite, IorD;
    logic       ALUSrcA, ALUSrcB, EXTOp;
    logic [3:0] ALUOp;
    logic [1:0] NPCOp, WDSel, GPRSel;
    logic [2:0] state;
    logic       illegal, done;

    int passed = 0;
    int total  = 0;

    mccpu_ctrl_fsm #(.JR_EN(1)) dut (
        .clk(clk), .rst(rst), .Op(Op), .Funct(Funct), .Zero(Zero),
        .PCWrite(PCWrite), .IRWrite(IRWrite), .MemWrite(MemWrite), .RFWrite(RFWrite),
        .IorD(IorD), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .EXTOp(EXTOp),
        .ALUOp(ALUOp), .NPCOp(NPCOp), .WDSel(WDSel), .GPRSel(GPRSel),
        .state(state), .illegal(illegal), .done(done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; Op = 6'h2B; Funct = 6'h00; Zero = 1'b0;
        tick(); tick();
        total++; if (state !== 3'd0) $display("FAIL rst_state got %0d exp 0", state); else passed++;
        total++; if ({MemWrite, RFWrite, PCWrite, IRWrite} !== 4'b0000)
            $display("FAIL rst_enables got %b exp 0000", {MemWrite, RFWrite, PCWrite, IRWrite}); else passed++;
        total++; if (ALUOp !== ALU_NOP) $display("FAIL rst_aluop got %0d exp %0d", ALUOp, ALU_NOP); else passed++;
        total++; if ({illegal, done} !== 2'b00) $display("FAIL rst_pulses got %b exp 00", {illegal, done}); else passed++;
        rst = 1'b0; #1;
        total++; if ({IRWrite, PCWrite, IorD, NPCOp} !== 5'b11000)
            $display("FAIL rel_fetch got %b exp 11000", {IRWrite, PCWrite, IorD, NPCOp}); else passed++;
    endtask

    task automatic test_addu();
        Op = 6'h00; Funct = 6'h21; #1;
        total++; if (state !== 3'd0) $display("FAIL addu_s0 got %0d exp 0", state); else passed++;
        tick();
        total++; if (state !== 3'd1) $display("FAIL addu_s1 got %0d exp 1", state); else passed++;
        tick();
        total++; if (state !== 3'd2) $display("FAIL addu_s2 got %0d exp 2", state); else passed++;
        total++; if ({ALUOp, ALUSrcA, ALUSrcB} !== {ALU_ADD, 2'b00})
            $display("FAIL addu_exe got %b exp %b", {ALUOp, ALUSrcA, ALUSrcB}, {ALU_ADD, 2'b00}); else passed++;
        tick();
        total++; if (state !== 3'd4) $display("FAIL addu_s4 got %0d exp 4", state); else passed++;
        total++; if ({RFWrite, GPRSel, WDSel, done} !== 6'b100000)
            $display("FAIL addu_wb got %b exp 100000", {RFWrite, GPRSel, WDSel, done}); else passed++;
        tick();
        total++; if ({state, done, illegal} !== 5'b00010)
            $display("FAIL addu_done got %b exp 00010", {state, done, illegal}); else passed++;
    endtask

    task automatic test_lw();
        Op = 6'h23; Funct = 6'h00; #1;
        tick(); tick();
        total++; if ({state, ALUOp, ALUSrcB, EXTOp} !== {3'd2, ALU_ADD, 2'b11})
            $display("FAIL lw_exe got %b exp %b", {state, ALUOp, ALUSrcB, EXTOp}, {3'd2, ALU_ADD, 2'b11}); else passed++;
        tick();
        total++; if ({state, IorD, MemWrite, RFWrite} !== {3'd3, 3'b100})
            $display("FAIL lw_mem got %b exp %b", {state, IorD, MemWrite, RFWrite}, {3'd3, 3'b100}); else passed++;
        tick();
        total++; if ({state, RFWrite, WDSel, GPRSel} !== {3'd4, 5'b10101})
            $display("FAIL lw_wb got %b exp %b", {state, RFWrite, WDSel, GPRSel}, {3'd4, 5'b10101}); else passed++;
        tick();
        total++; if ({state, done} !== 4'b0001) $display("FAIL lw_done got %b exp 0001", {state, done}); else passed++;
    endtask

    task automatic test_beq();
        Op = 6'h04; Funct = 6'h00; Zero = 1'b1; #1;
        tick(); tick();
        total++; if ({state, PCWrite, NPCOp, ALUOp, ALUSrcB} !== {3'd2, 3'b101, ALU_SUB, 1'b0})
            $display("FAIL beq_taken got %b exp %b", {state, PCWrite, NPCOp, ALUOp, ALUSrcB},
                     {3'd2, 3'b101, ALU_SUB, 1'b0}); else passed++;
        tick();
        total++; if ({state, done} !== 4'b0001) $display("FAIL beq_taken_done got %b exp 0001", {state, done}); else passed++;
        Zero = 1'b0; #1;
        tick(); tick();
        total++; if ({state, PCWrite, NPCOp} !== {3'd2, 3'b001})
            $display("FAIL beq_nt got %b exp %b", {state, PCWrite, NPCOp}, {3'd2, 3'b001}); else passed++;
        tick();
        total++; if ({state, done} !== 4'b0001) $display("FAIL beq_nt_done got %b exp 0001", {state, done}); else passed++;
    endtask

    task automatic test_jal_illegal();
        Op = 6'h03; Funct = 6'h00; #1;
        tick();
        total++; if ({state, PCWrite, NPCOp, RFWrite, GPRSel, WDSel} !== {3'd1, 8'b11011010})
            $display("FAIL jal_dcode got %b exp %b", {state, PCWrite, NPCOp, RFWrite, GPRSel, WDSel},
                     {3'd1, 8'b11011010}); else passed++;
        tick();
        total++; if ({state, done} !== 4'b0001) $display("FAIL jal_done got %b exp 0001", {state, done}); else passed++;
        Op = 6'h3F; #1;
        tick();
        total++; if ({state, PCWrite, IRWrite, MemWrite, RFWrite} !== {3'd1, 4'b0000})
            $display("FAIL ill_dcode got %b exp %b", {state, PCWrite, IRWrite, MemWrite, RFWrite}, {3'd1, 4'b0000}); else passed++;
        tick();
        total++; if ({state, illegal, done} !== 5'b00010)
            $display("FAIL ill_pulse got %b exp 00010", {state, illegal, done}); else passed++;
    endtask

    task automatic test_jr_sll_ori();
        Op = 6'h00; Funct = 6'h08; #1;
        tick();
        total++; if ({illegal, PCWrite, NPCOp, RFWrite} !== 5'b01110)
            $display("FAIL jr_dcode got %b exp 01110", {illegal, PCWrite, NPCOp, RFWrite}); else passed++;
        tick();
        total++; if ({state, done} !== 4'b0001) $display("FAIL jr_done got %b exp 0001", {state, done}); else passed++;
        Funct = 6'h00; #1;
        tick(); tick();
        total++; if ({ALUOp, ALUSrcA, ALUSrcB} !== {ALU_SLL, 2'b10})
            $display("FAIL sll_exe got %b exp %b", {ALUOp, ALUSrcA, ALUSrcB}, {ALU_SLL, 2'b10}); else passed++;
        tick(); tick();
        Op = 6'h0D; #1;
        tick(); tick();
        total++; if ({ALUOp, ALUSrcB, EXTOp} !== {ALU_OR, 2'b10})
            $display("FAIL ori_exe got %b exp %b", {ALUOp, ALUSrcB, EXTOp}, {ALU_OR, 2'b10}); else passed++;
        tick();
        total++; if ({state, RFWrite, GPRSel, WDSel, ALUOp} !== {3'd4, 5'b10100, ALU_NOP})
            $display("FAIL ori_wb got %b exp %b", {state, RFWrite, GPRSel, WDSel, ALUOp}, {3'd4, 5'b10100, ALU_NOP}); else passed++;
        tick();
    endtask

    task automatic test_sw_rst();
        Op = 6'h2B; Funct = 6'h00; #1;
        tick();
        total++; if ({state, illegal} !== 4'b0010) $display("FAIL sw_dcode got %b exp 0010", {state, illegal}); else passed++;
        tick(); tick();
        total++; if ({state, MemWrite, IorD} !== {3'd3, 2'b11})
            $display("FAIL sw_mem got %b exp %b", {state, MemWrite, IorD}, {3'd3, 2'b11}); else passed++;
        rst = 1'b1; #1;
        total++; if ({state, MemWrite, IorD} !== {3'd3, 2'b00})
            $display("FAIL sw_rst_mem got %b exp %b", {state, MemWrite, IorD}, {3'd3, 2'b00}); else passed++;
        tick();
        total++; if ({state, done} !== 4'b0000) $display("FAIL sw_rst_state got %b exp 0000", {state, done}); else passed++;
        rst = 1'b0; #1;
        total++; if ({state, done, illegal, IRWrite} !== 6'b000001)
            $display("FAIL sw_release got %b exp 000001", {state, done, illegal, IRWrite}); else passed++;
    endtask

    initial begin
        test_reset();
        test_addu();
        test_lw();
        test_beq();
        test_jal_illegal();
        test_jr_sll_ori();
        test_sw_rst();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
